// File: rtl/onehot_step_decoder.sv
// Registered binary-to-one-hot decoder with a small sequencer that can rotate
// the active bit left/right with wrap-around or scan it upward to the MSB.
module onehot_step_decoder #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             step_en,
  input  logic             stop,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Handshake: start is taken only while busy==0; a start seen together with
  // stop, or at any time during RUN, is dropped. done/err are one-cycle pulses.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_ROT_L  = 2'b01,
    MODE_ROT_R  = 2'b10,
    MODE_SCAN   = 2'b11
  } mode_e;

  localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W - 1);
  localparam logic [SEL_W:0]   OUT_LIM = (SEL_W + 1)'(OUT_W);
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

  state_e           state;
  mode_e            mode_q;
  logic [SEL_W-1:0] pos_inc;
  logic [SEL_W-1:0] pos_dec;
  logic             sel_ok;

  // Wrap by explicit compare so non-power-of-two OUT_W behaves.
  always_comb begin
    pos_inc = (pos == LAST) ? '0 : pos + 1'b1;
    pos_dec = (pos == '0) ? LAST : pos - 1'b1;
    sel_ok  = ({1'b0, sel} < OUT_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      mode_q <= MODE_DECODE;
      out    <= '0;
      pos    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode_e'(mode);
            if (!sel_ok) begin
              out <= '0;
              pos <= '0;
              err <= 1'b1;
            end else begin
              out <= ONE << sel;
              pos <= sel;
              if (mode_e'(mode) == MODE_DECODE) begin
                done <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step_en) begin
            case (mode_q)
              MODE_ROT_L: begin
                pos <= pos_inc;
                out <= ONE << pos_inc;
              end
              MODE_ROT_R: begin
                pos <= pos_dec;
                out <= ONE << pos_dec;
              end
              MODE_SCAN: begin
                if (pos == LAST) begin
                  out   <= '0;
                  pos   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  pos <= pos + 1'b1;
                  out <= ONE << (pos + 1'b1);
                end
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/onehot_step_decoder.md
# onehot_step_decoder

Parametrised, registered binary-to-one-hot decoder with a sequencing engine. Besides a plain registered decode, it can rotate the active bit left or right with wrap-around, or scan it upward to the MSB and finish. It drives one-hot select/enable vectors, such as bank enables or LED/column scan lines, with a start/stop handshake toward the controlling FSM.

## Interface
- SEL_W, default 3: width of `sel` and of `pos`.
- OUT_W, default 8: width of `out`. Constraint: 2 <= OUT_W <= 2**SEL_W.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low. reset==0 at a rising edge clears the block.
- start  input  1  request; sampled only when busy==0.
- mode  input  2  latched at accepted start. 00 DECODE, 01 ROT_L, 10 ROT_R, 11 SCAN.
- sel  input  SEL_W  start index; latched at accepted start.
- step_en  input  1  advance one position per cycle while running.
- stop  input  1  terminate a running ROT_L, ROT_R or SCAN.
- out  output  OUT_W  registered one-hot vector, or all-zero.
- pos  output  SEL_W  registered binary index of the active bit; 0 when out==0.
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse at completion.
- err  output  1  one-cycle pulse on an out-of-range sel.

## Operation
- States are IDLE and RUN, encoded in 1 bit. Mode is held in a 2-bit register latched at start.
- **Reset:** reset==0 at an edge gives state=IDLE, out=0, pos=0, busy=0, done=0, err=0, mode register=00.
  - Reset has priority over every other input.
  - Reset during RUN aborts with no done pulse.
- **IDLE, start==1, sel>=OUT_W:** out<=0, pos<=0, err<=1. State stays IDLE. No done.
- **IDLE, start==1, sel<OUT_W:** out<=1<<sel, pos<=sel.
  - DECODE: state stays IDLE, done<=1.
  - ROT_L, ROT_R, SCAN: state<=RUN, busy<=1.
- **IDLE, start==0:** out and pos hold.
- **RUN:** start is ignored. Input priority is stop, then step_en.
  - stop==1: state<=IDLE, busy<=0, done<=1. out and pos hold their current value, and step_en is ignored that cycle.
  - step_en==1, ROT_L: pos<=(pos==OUT_W-1)?0:pos+1, and out follows pos.
  - step_en==1, ROT_R: pos<=(pos==0)?OUT_W-1:pos-1, and out follows pos.
  - step_en==1, SCAN, pos<OUT_W-1: pos<=pos+1.
  - step_en==1, SCAN, pos==OUT_W-1: out<=0, pos<=0, state<=IDLE, busy<=0, done<=1.
  - step_en==0: hold.
- **Invariants:** out==(1<<pos) or out==0, and out is never multi-hot. pos never reaches or exceeds OUT_W.
- **Widths:** pos arithmetic is SEL_W bits. The wrap is an explicit compare against OUT_W-1, not a natural overflow, so non-power-of-two OUT_W wraps correctly.
- done and err are 0 by default every cycle and are never asserted together.

## Timing
- All outputs are registered, and all inputs are sampled on the rising edge.
- Start-to-out latency is 1 cycle. For a start sampled at edge t, out, pos, busy and err/done are valid after edge t.
- Each step takes 1 cycle per asserted step_en. There is no internal prescaler; the caller throttles with step_en.
- The done pulse lands in the same cycle as the final out value. For SCAN this is the cycle where out becomes 0.
- Back-to-back operation: in the cycle after done, busy==0, so a start there is accepted. A start on the same cycle stop is sampled is ignored.
- Operations per run:
  - DECODE: 1 cycle, throughput 1 per cycle.
  - SCAN from sel: exactly OUT_W-sel steps to done.
  - ROT: unbounded until stop.

## Test plan
- **Reset:** Hold reset=0 for 2 cycles while driving start=1, mode=01, sel=3. Required: out=0, pos=0, busy=0, done=0 and err=0 throughout.
- **DECODE sweep (defaults):** Issue start with mode=00 and sel=0..7 on consecutive cycles. Required: out=0x01,0x02,…,0x80 one cycle after each start, done=1 every cycle, busy=0.
- **ROT_L wrap:** Start with sel=6, mode=01, then hold step_en=1 for 3 cycles. Required: out=0x40 → 0x80 → 0x01 → 0x02, pos=6,7,0,1. Then assert stop: out stays 0x02, done=1 for one cycle, busy=0.
- **ROT_R wrap with OUT_W=5, SEL_W=3:** Start with sel=1, mode=10, then step twice. Required: out=5'b00010 → 5'b00001 → 5'b10000, pos=1,0,4.
- **SCAN plus out-of-range sel (OUT_W=5):**
  - Start with sel=3, mode=11, then hold step_en=1. Required: out=0x08 → 0x10 → 0x00, with done on the 0x00 cycle after exactly 2 steps.
  - Then start with sel=6. Required: err=1 for one cycle, out=0, state stays IDLE.
- **Collisions:**
  - In RUN, drive stop=1 and step_en=1 in the same cycle. Required: out unchanged, done=1.
  - In RUN, drive start=1. Required: start is ignored.
  - At pos=5 of ROT_L, drive reset=0. Required: out=0, busy=0, and no done pulse.
